divisor_top: RTL and testbench

- Sequential 8-bit integer divider; the inverse operation of the team's combinational multiplier block in the ALU datapath.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- start/busy/done handshake so the ALU controller can launch a division and collect quotient and remainder.

---
 rtl/divisor_top.sv | 146 ++++++++++++++
 tb/tb_divisor_top.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/divisor_top.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro DIVISOR_SIGNED_EN selects two's-complement operands with a sign fix-up cycle.
module divisor_top #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] data0_i,
   input  logic [WIDTH-1:0] data1_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div0_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] rem_r;
   logic             zero_r;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH-1:0] diff_s;
   logic             qbit_s;
   logic [WIDTH-1:0] rem_nxt_s;
   logic [WIDTH-1:0] quo_nxt_s;

`ifdef DIVISOR_SIGNED_EN
   logic fix_r;
   logic neg_q_r;
   logic neg_r_r;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      mag = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction
`endif

   // The quotient shifts into dvd_r as the dividend bits shift out of it.
   // The subtraction is only kept when shifted >= divisor, so a WIDTH-bit difference is exact.
   assign shifted_s = {rem_r, dvd_r[WIDTH-1]};
   assign qbit_s    = (shifted_s >= {1'b0, dvs_r});
   assign diff_s    = shifted_s[WIDTH-1:0] - dvs_r;
   assign rem_nxt_s = qbit_s ? diff_s : shifted_s[WIDTH-1:0];
   assign quo_nxt_s = {dvd_r[WIDTH-2:0], qbit_s};

   // Control FSM, datapath iteration and registered result outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         dvd_r       <= '0;
         dvs_r       <= '0;
         rem_r       <= '0;
         zero_r      <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         result_o    <= '0;
         remainder_o <= '0;
         div0_o      <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
         fix_r       <= 1'b0;
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  rem_r   <= '0;
                  cnt_r   <= CW'(WIDTH - 1);
                  zero_r  <= (data1_i == '0);
                  busy_o  <= (data1_i != '0);
                  state_r <= ST_BUSY;
`ifdef DIVISOR_SIGNED_EN
                  // A zero divisor keeps the raw dividend so it can be returned as remainder.
                  dvd_r   <= (data1_i == '0) ? data0_i : mag(data0_i);
                  dvs_r   <= mag(data1_i);
                  neg_q_r <= data0_i[WIDTH-1] ^ data1_i[WIDTH-1];
                  neg_r_r <= data0_i[WIDTH-1];
                  fix_r   <= 1'b0;
`else
                  dvd_r   <= data0_i;
                  dvs_r   <= data1_i;
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (zero_r) begin
                  result_o    <= '1;
                  remainder_o <= dvd_r;
                  div0_o      <= 1'b1;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  zero_r      <= 1'b0;
                  state_r     <= ST_DONE;
               end
`ifdef DIVISOR_SIGNED_EN
               else if (fix_r) begin
                  result_o    <= neg_q_r ? (~dvd_r + WIDTH'(1)) : dvd_r;
                  remainder_o <= neg_r_r ? (~rem_r + WIDTH'(1)) : rem_r;
                  div0_o      <= 1'b0;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  fix_r       <= 1'b0;
                  state_r     <= ST_DONE;
               end
`endif
               else begin
                  dvd_r <= quo_nxt_s;
                  rem_r <= rem_nxt_s;
                  cnt_r <= cnt_r - CW'(1);
                  if (cnt_r == '0) begin
`ifdef DIVISOR_SIGNED_EN
                     fix_r <= 1'b1;
`else
                     result_o    <= quo_nxt_s;
                     remainder_o <= rem_nxt_s;
                     div0_o      <= 1'b0;
                     done_o      <= 1'b1;
                     busy_o      <= 1'b0;
                     state_r     <= ST_DONE;
`endif
                  end
               end
            end
            default: begin
               busy_o  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_top.sv
// Scoreboard bench for divisor_top: expectations queued at the accepting edge, compared on done_o.
module tb_divisor_top;

   localparam int WIDTH  = 8;
   localparam int PERIOD = 10;
`ifdef DIVISOR_SIGNED_EN
   localparam int LAT = WIDTH + 1;
`else
   localparam int LAT = WIDTH;
`endif

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             z;
      int               lat;
      longint           t;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] remainder;
   logic             div0;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   busy_cnt = 0;

   divisor_top #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .data0_i    (d0),
      .data1_i    (d1),
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result),
      .remainder_o(remainder),
      .div0_o     (div0)
   );

   always #(PERIOD/2) clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      e.t = 0;
      if (b == '0) begin
         e.q = '1; e.r = a; e.z = 1'b1; e.lat = 1;
      end else begin
         e.z = 1'b0; e.lat = LAT;
`ifdef DIVISOR_SIGNED_EN
         if (a == 8'h80 && b == 8'hFF) begin
            e.q = 8'h80; e.r = 8'h00;
         end else begin
            e.q = WIDTH'($signed(a) / $signed(b));
            e.r = WIDTH'($signed(a) % $signed(b));
         end
`else
         e.q = a / b;
         e.r = a % b;
`endif
      end
      return e;
   endfunction

   // Output monitor: pops the scoreboard on every done_o pulse
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (!rst_n) begin
         busy_cnt = 0;
      end else if (done) begin
         check_eq("busy_in_done", busy, 1'b0);
         if (sb.size() == 0) begin
            check_eq("spurious_done", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check_eq("quotient", result, e.q);
            check_eq("remainder", remainder, e.r);
            check_eq("div0", div0, e.z);
            check_eq("latency", 32'(($time - 1 - e.t) / PERIOD), e.lat);
            check_eq("busy_cycles", busy_cnt, e.z ? 0 : e.lat);
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end
   end

   task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
      exp_t e;
      @(negedge clk);
      start = 1'b1; d0 = a; d1 = b;
      @(posedge clk);
      e   = model(a, b);
      e.t = $time;
      sb.push_back(e);
      #1;
      if (!hold) start = 1'b0;
      d0 = WIDTH'($urandom);
      d1 = WIDTH'($urandom);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check_eq("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin
      exp_t h;
      bit   seen;
      rst_n = 1'b0; start = 1'b0; d0 = '0; d1 = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_result", result, 0);
      check_eq("rst_remainder", remainder, 0);
      check_eq("rst_div0", div0, 1'b0);
      rst_n = 1'b1;

      // Basic division and output hold
      launch(8'd200, 8'd7, 1'b0);
      wait_drain();
      repeat (3) @(negedge clk);
      h = model(8'd200, 8'd7);
      check_eq("hold_quotient", result, h.q);
      check_eq("hold_remainder", remainder, h.r);

      // Divide by zero, then a normal division clears div0
      launch(8'd55, 8'd0, 1'b0);
      wait_drain();
      launch(8'd255, 8'd1, 1'b0);
      wait_drain();

      // Start while busy is ignored
      launch(8'd100, 8'd10, 1'b0);
      repeat (2) @(negedge clk);
      start = 1'b1; d0 = 8'd9; d1 = 8'd3;
      @(negedge clk);
      start = 1'b0;
      wait_drain();
      repeat (12) @(negedge clk);

      // Back-to-back: start held through DONE
      launch(8'd17, 8'd5, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq("b2b_done_seen", seen, 1'b1);
      d0 = 8'd250; d1 = 8'd9;
      @(posedge clk);
      if (seen) begin
         h   = model(8'd250, 8'd9);
         h.t = $time;
         sb.push_back(h);
      end
      #1 start = 1'b0;
      wait_drain();

      // Reset mid-operation
      launch(8'd250, 8'd3, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_done", done, 1'b0);
      check_eq("abort_result", result, 0);
      check_eq("abort_remainder", remainder, 0);
      check_eq("abort_div0", div0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      launch(8'd9, 8'd4, 1'b0);
      wait_drain();

      // Sign-sensitive and boundary operands
      launch(8'h9C, 8'h07, 1'b0);
      wait_drain();
      launch(8'h80, 8'hFF, 1'b0);
      wait_drain();
      launch(8'h80, 8'h01, 1'b0);
      wait_drain();
      launch(8'h7F, 8'hFF, 1'b0);
      wait_drain();
      launch(8'h05, 8'hC8, 1'b0);
      wait_drain();

      for (int i = 0; i < 8; i++) begin
         launch(WIDTH'($urandom), WIDTH'($urandom_range(1, 255)), 1'b0);
         wait_drain();
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
